// File: rtl/pattern_gen_multi_if.sv
// Pixel-stream link between the pattern generator and the serialiser.
// The serialiser paces reads/lines/frames; the generator returns pixels.
interface pattern_gen_multi_if #(
  parameter int BITS_PER_COLOR = 8
);
  logic                          i_rd;
  logic                          i_newline;
  logic                          i_newframe;
  logic [3*BITS_PER_COLOR-1:0]   o_pixel;

  modport master (
    output i_rd, i_newline, i_newframe,
    input  o_pixel
  );

  modport slave (
    input  i_rd, i_newline, i_newframe,
    output o_pixel
  );
endinterface

// File: rtl/pattern_gen_multi.sv
// Multi-mode test pattern source: bars, checker, ramp, solid, bouncing box.
// Position and pixel are registered from next-state, so output is zero latency.
module pattern_gen_multi #(
  parameter int BITS_PER_COLOR = 8,
  parameter int HW             = 12,
  parameter int VW             = 11,
  parameter int CHK_LOG2       = 4,
  parameter int BOX_SIZE       = 32,
  parameter int FCW            = 16
) (
  input  logic                        i_pixclk,
  input  logic                        i_reset,
  input  logic [HW-1:0]               i_width,
  input  logic [VW-1:0]               i_height,
  input  logic [2:0]                  i_mode,
  input  logic [3*BITS_PER_COLOR-1:0] i_solid,
  pattern_gen_multi_if.slave          bus,
  output logic [HW-1:0]               o_hpos,
  output logic [VW-1:0]               o_vpos,
  output logic [FCW-1:0]              o_frame,
  output logic                        o_overrun
);
  localparam int PW = 3*BITS_PER_COLOR;
  localparam int AW = HW+1;
  localparam int BPC = BITS_PER_COLOR;

  localparam logic [2:0] M_BARS  = 3'd0;
  localparam logic [2:0] M_CHECK = 3'd1;
  localparam logic [2:0] M_RAMP  = 3'd2;
  localparam logic [2:0] M_SOLID = 3'd3;
  localparam logic [2:0] M_BOX   = 3'd4;

  logic [HW-1:0]  r_hpos, w_hpos;
  logic [VW-1:0]  r_vpos, w_vpos;
  logic [FCW-1:0] r_frame, w_frame;
  logic [2:0]     r_mode, w_mode;
  logic           r_ovr, w_ovr;
  logic [HW-1:0]  r_bx, w_bx;
  logic [VW-1:0]  r_by, w_by;
  logic           r_dxn, w_dxn;
  logic           r_dyn, w_dyn;
  logic [2:0]     r_bar, w_bar;
  logic [AW-1:0]  r_acc, w_acc;
  logic [AW-1:0]  w_acc_sum;
  logic [HW-1:0]  w_xlim;
  logic [VW-1:0]  w_ylim;
  logic [PW-1:0]  r_pix, w_pix;
  logic [HW:0]    w_bx_end;
  logic [VW:0]    w_by_end;
  logic           w_in_box;

  assign w_xlim = i_width - HW'(BOX_SIZE);
  assign w_ylim = i_height - VW'(BOX_SIZE);
  assign w_acc_sum = r_acc + AW'(8);

  always_comb begin
    w_hpos  = r_hpos;
    w_vpos  = r_vpos;
    w_frame = r_frame;
    w_mode  = r_mode;
    w_ovr   = r_ovr;
    w_bx    = r_bx;
    w_by    = r_by;
    w_dxn   = r_dxn;
    w_dyn   = r_dyn;
    w_bar   = r_bar;
    w_acc   = r_acc;
    if (bus.i_newframe) begin
      w_hpos  = '0;
      w_vpos  = '0;
      w_frame = r_frame + 1'b1;
      w_mode  = i_mode;
      w_ovr   = 1'b0;
      w_bar   = '0;
      w_acc   = '0;
      // Reverse before stepping so the box never overshoots an edge.
      if (i_width <= HW'(BOX_SIZE)) begin
        w_bx = '0;
      end else if (!r_dxn) begin
        if (r_bx >= w_xlim) begin
          w_dxn = 1'b1;
          w_bx  = r_bx - 1'b1;
        end else begin
          w_bx = r_bx + 1'b1;
        end
      end else if (r_bx == '0) begin
        w_dxn = 1'b0;
        w_bx  = HW'(1);
      end else begin
        w_bx = r_bx - 1'b1;
      end
      if (i_height <= VW'(BOX_SIZE)) begin
        w_by = '0;
      end else if (!r_dyn) begin
        if (r_by >= w_ylim) begin
          w_dyn = 1'b1;
          w_by  = r_by - 1'b1;
        end else begin
          w_by = r_by + 1'b1;
        end
      end else if (r_by == '0) begin
        w_dyn = 1'b0;
        w_by  = VW'(1);
      end else begin
        w_by = r_by - 1'b1;
      end
    end else if (bus.i_newline) begin
      w_hpos = '0;
      w_bar  = '0;
      w_acc  = '0;
      if (r_vpos == i_height - VW'(1)) w_ovr = 1'b1;
      else w_vpos = r_vpos + 1'b1;
    end else if (bus.i_rd) begin
      if (r_hpos == i_width - HW'(1)) begin
        w_ovr = 1'b1;
      end else begin
        w_hpos = r_hpos + 1'b1;
        // width >= 8 keeps acc+8 below 2*width: one subtract suffices
        if (w_acc_sum >= {1'b0, i_width}) begin
          w_acc = w_acc_sum - {1'b0, i_width};
          if (r_bar != 3'd7) w_bar = r_bar + 1'b1;
        end else begin
          w_acc = w_acc_sum;
        end
      end
    end
  end

  assign w_bx_end = {1'b0, w_bx} + (HW+1)'(BOX_SIZE);
  assign w_by_end = {1'b0, w_by} + (VW+1)'(BOX_SIZE);
  assign w_in_box = (w_hpos >= w_bx) && ({1'b0, w_hpos} < w_bx_end) &&
                    (w_vpos >= w_by) && ({1'b0, w_vpos} < w_by_end);

  always_comb begin
    w_pix = '0;
    unique case (1'b1)
      (w_mode == M_BARS):
        w_pix = {{BPC{~w_bar[1]}}, {BPC{~w_bar[2]}}, {BPC{~w_bar[0]}}};
      (w_mode == M_CHECK):
        w_pix = (w_hpos[CHK_LOG2] ^ w_vpos[CHK_LOG2]) ? '1 : '0;
      (w_mode == M_RAMP):
        w_pix = {3{w_hpos[BPC-1:0]}};
      (w_mode == M_SOLID):
        w_pix = i_solid;
      (w_mode == M_BOX):
        w_pix = w_in_box ? '1 : '0;
      default:
        w_pix = '0;
    endcase
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      r_hpos  <= '0;
      r_vpos  <= '0;
      r_frame <= '0;
      r_mode  <= M_BARS;
      r_ovr   <= 1'b0;
      r_bx    <= '0;
      r_by    <= '0;
      r_dxn   <= 1'b0;
      r_dyn   <= 1'b0;
      r_bar   <= '0;
      r_acc   <= '0;
      r_pix   <= '1;
    end else begin
      r_hpos  <= w_hpos;
      r_vpos  <= w_vpos;
      r_frame <= w_frame;
      r_mode  <= w_mode;
      r_ovr   <= w_ovr;
      r_bx    <= w_bx;
      r_by    <= w_by;
      r_dxn   <= w_dxn;
      r_dyn   <= w_dyn;
      r_bar   <= w_bar;
      r_acc   <= w_acc;
      r_pix   <= w_pix;
    end
  end

  // Solid colour tracks i_solid live rather than one cycle late.
  assign bus.o_pixel = (r_mode == M_SOLID) ? i_solid : r_pix;
  assign o_hpos    = r_hpos;
  assign o_vpos    = r_vpos;
  assign o_frame   = r_frame;
  assign o_overrun = r_ovr;
endmodule

// File: tb/tb_pattern_gen_multi.sv
// Scoreboard bench for pattern_gen_multi: reference model pushes expected
// output per cycle; each test task pops and compares after the clock edge.
module tb_pattern_gen_multi;
  typedef struct packed {
    logic [23:0] pix;
    logic [11:0] h;
    logic [10:0] v;
    logic [15:0] f;
    logic        ovr;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [11:0] i_width;
  logic [10:0] i_height;
  logic [2:0]  i_mode;
  logic [23:0] i_solid;
  logic [11:0] o_hpos;
  logic [10:0] o_vpos;
  logic [15:0] o_frame;
  logic        o_overrun;

  pattern_gen_multi_if #(.BITS_PER_COLOR(8)) bus ();

  pattern_gen_multi dut (
    .i_pixclk (clk),
    .i_reset  (i_reset),
    .i_width  (i_width),
    .i_height (i_height),
    .i_mode   (i_mode),
    .i_solid  (i_solid),
    .bus      (bus),
    .o_hpos   (o_hpos),
    .o_vpos   (o_vpos),
    .o_frame  (o_frame),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  exp_t obs;
  assign obs = {bus.o_pixel, o_hpos, o_vpos, o_frame, o_overrun};

  exp_t q[$];
  int n_pass = 0;
  int n_total = 0;

  int m_h, m_v, m_frame, m_mode, m_bx, m_by;
  bit m_ovr, m_dxn, m_dyn;

  function automatic logic [23:0] exp_pix();
    int b;
    logic [7:0] g;
    case (m_mode)
      0: begin
        b = (8 * m_h) / int'(i_width);
        case (b)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      1: return ((((m_h >> 4) ^ (m_v >> 4)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
      2: begin
        g = m_h[7:0];
        return {g, g, g};
      end
      3: return i_solid;
      4: return (m_h >= m_bx && m_h < m_bx + 32 &&
                 m_v >= m_by && m_v < m_by + 32) ? 24'hFFFFFF : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  task automatic box_step(inout int p, inout bit neg, input int size);
    if (size <= 32) p = 0;
    else if (!neg) begin
      if (p + 1 > size - 32) begin neg = 1; p = p - 1; end
      else p = p + 1;
    end else if (p == 0) begin neg = 0; p = 1; end
    else p = p - 1;
  endtask

  task automatic step(input logic rd, input logic nl, input logic nf);
    exp_t e;
    bus.i_rd = rd;
    bus.i_newline = nl;
    bus.i_newframe = nf;
    if (i_reset) begin
      m_h = 0; m_v = 0; m_frame = 0; m_mode = 0; m_ovr = 0;
      m_bx = 0; m_by = 0; m_dxn = 0; m_dyn = 0;
    end else if (nf) begin
      m_h = 0; m_v = 0; m_frame = (m_frame + 1) % 65536;
      m_mode = int'(i_mode); m_ovr = 0;
      box_step(m_bx, m_dxn, int'(i_width));
      box_step(m_by, m_dyn, int'(i_height));
    end else if (nl) begin
      m_h = 0;
      if (m_v == int'(i_height) - 1) m_ovr = 1;
      else m_v++;
    end else if (rd) begin
      if (m_h == int'(i_width) - 1) m_ovr = 1;
      else m_h++;
    end
    e.pix = exp_pix();
    e.h = m_h[11:0];
    e.v = m_v[10:0];
    e.f = m_frame[15:0];
    e.ovr = m_ovr;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    i_reset = 1'b1;
    step(0, 0, 0);
    i_reset = 1'b0;
    e = q.pop_front();
    n_total++;
    if (obs !== e) $display("FAIL reset_sb got=%h want=%h", obs, e);
    else n_pass++;
    n_total++;
    if (obs !== {24'hFFFFFF, 12'd0, 11'd0, 16'd0, 1'b0})
      $display("FAIL reset_state got=%h want=ffffff0000000000", obs);
    else n_pass++;
  endtask

  task automatic test_bars();
    exp_t e;
    logic [23:0] want;
    for (int k = 1; k <= 640; k++) begin
      step(1, 0, 0);
      e = q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL bars_sb k=%0d got=%h want=%h", k, obs, e);
      else n_pass++;
      if (k < 80 || k == 80 || k == 160 || k == 639) begin
        want = (k < 80) ? 24'hFFFFFF : (k == 80) ? 24'hFFFF00 :
               (k == 160) ? 24'h00FFFF : 24'h000000;
        n_total++;
        if (bus.o_pixel !== want)
          $display("FAIL bars_px k=%0d got=%h want=%h", k, bus.o_pixel, want);
        else n_pass++;
      end
    end
    n_total++;
    if (o_overrun !== 1'b1 || o_hpos !== 12'd639)
      $display("FAIL bars_ovr got ovr=%b h=%0d want ovr=1 h=639", o_overrun, o_hpos);
    else n_pass++;
  endtask

  task automatic test_checker();
    exp_t e;
    logic [23:0] want;
    i_mode = 3'd1;
    step(0, 0, 1);
    e = q.pop_front();
    n_total++;
    if (obs !== e) $display("FAIL chk_nf got=%h want=%h", obs, e);
    else n_pass++;
    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 0);
      e = q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL chk_sb got=%h want=%h", obs, e);
      else n_pass++;
      if (k >= 15) begin
        want = (k == 15) ? 24'h000000 : 24'hFFFFFF;
        n_total++;
        if (bus.o_pixel !== want)
          $display("FAIL chk_px h=%0d got=%h want=%h", k, bus.o_pixel, want);
        else n_pass++;
      end
    end
    for (int k = 0; k < 32; k++) begin
      step(k < 16 ? 1'b0 : 1'b1, k < 16 ? 1'b1 : 1'b0, 0);
      e = q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL chk_sb2 got=%h want=%h", obs, e);
      else n_pass++;
    end
    n_total++;
    if (bus.o_pixel !== 24'h0 || o_hpos !== 12'd16 || o_vpos !== 11'd16)
      $display("FAIL chk_16_16 got=%h h=%0d v=%0d want=000000", bus.o_pixel, o_hpos, o_vpos);
    else n_pass++;
    while (m_v < 479) begin
      step(0, 1, 0);
      e = q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL chk_nl got=%h want=%h", obs, e);
      else n_pass++;
    end
    step(0, 1, 0);
    e = q.pop_front();
    n_total++;
    if (o_overrun !== 1'b1 || o_vpos !== 11'd479 || obs !== e)
      $display("FAIL chk_vovr got ovr=%b v=%0d want ovr=1 v=479", o_overrun, o_vpos);
    else n_pass++;
  endtask

  task automatic test_ramp();
    exp_t e;
    logic [23:0] want;
    i_mode = 3'd2;
    step(0, 0, 1);
    e = q.pop_front();
    n_total++;
    if (o_overrun !== 1'b0 || obs !== e)
      $display("FAIL ramp_clr got ovr=%b want ovr=0", o_overrun);
    else n_pass++;
    for (int k = 1; k <= 300; k++) begin
      step(1, 0, 0);
      e = q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL ramp_sb got=%h want=%h", obs, e);
      else n_pass++;
      if (k == 255 || k == 256 || k == 300) begin
        want = (k == 255) ? 24'hFFFFFF : (k == 256) ? 24'h000000 : 24'h2C2C2C;
        n_total++;
        if (bus.o_pixel !== want)
          $display("FAIL ramp_px h=%0d got=%h want=%h", k, bus.o_pixel, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int f0;
    i_solid = 24'h123456;
    i_mode = 3'd3;
    step(0, 0, 1);
    step(0, 1, 0);
    for (int k = 0; k < 5; k++) step(1, 0, 0);
    i_solid = 24'hABCDEF;
    step(0, 0, 0);
    n_total++;
    if (bus.o_pixel !== 24'hABCDEF)
      $display("FAIL solid_live got=%h want=abcdef", bus.o_pixel);
    else n_pass++;
    i_mode = 3'd0;
    for (int k = 0; k < 3; k++) step(1, 0, 0);
    n_total++;
    if (bus.o_pixel !== 24'hABCDEF || o_hpos !== 12'd8)
      $display("FAIL mode_hold got=%h h=%0d want=abcdef h=8", bus.o_pixel, o_hpos);
    else n_pass++;
    f0 = m_frame;
    step(1, 1, 1);
    n_total++;
    if (o_hpos !== 12'd0 || o_vpos !== 11'd0 ||
        o_frame !== 16'(f0 + 1) || bus.o_pixel !== 24'hFFFFFF)
      $display("FAIL all_events got h=%0d v=%0d f=%0d px=%h want h=0 v=0 f=%0d px=ffffff",
               o_hpos, o_vpos, o_frame, bus.o_pixel, f0 + 1);
    else n_pass++;
    while (q.size() > 0) begin
      e = q.pop_front();
      n_total++;
      if (q.size() == 0 && obs !== e) $display("FAIL b2b_sb got=%h want=%h", obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int k = 0; k < 10; k++) step(0, 1, 0);
    for (int k = 0; k < 200; k++) step(1, 0, 0);
    while (q.size() > 1) void'(q.pop_front());
    e = q.pop_front();
    n_total++;
    if (obs !== e || o_hpos !== 12'd200 || o_vpos !== 11'd10)
      $display("FAIL pre_reset got=%h want=%h", obs, e);
    else n_pass++;
    i_reset = 1'b1;
    step(1, 1, 1);
    i_reset = 1'b0;
    e = q.pop_front();
    n_total++;
    if (obs !== e || obs !== {24'hFFFFFF, 12'd0, 11'd0, 16'd0, 1'b0})
      $display("FAIL reset_mid got=%h want=ffffff0000000000", obs);
    else n_pass++;
  endtask

  task automatic test_box();
    exp_t e;
    int stop;
    logic [23:0] want;
    i_width = 12'd64;
    i_reset = 1'b1;
    step(0, 0, 0);
    i_reset = 1'b0;
    void'(q.pop_front());
    i_mode = 3'd4;
    for (int f = 1; f <= 40; f++) begin
      step(0, 0, 1);
      e = q.pop_front();
      n_total++;
      if (obs !== e) $display("FAIL box_nf f=%0d got=%h want=%h", f, obs, e);
      else n_pass++;
      while (m_v < m_by) begin
        step(0, 1, 0);
        e = q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL box_nl got=%h want=%h", obs, e);
        else n_pass++;
      end
      stop = (m_bx + 32 > 63) ? 63 : m_bx + 32;
      while (m_h < stop) begin
        step(1, 0, 0);
        e = q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL box_sb f=%0d got=%h want=%h", f, obs, e);
        else n_pass++;
        if (m_h == m_bx || m_h == m_bx - 1 || m_h == m_bx + 32) begin
          want = (m_h == m_bx) ? 24'hFFFFFF : 24'h000000;
          n_total++;
          if (bus.o_pixel !== want)
            $display("FAIL box_edge f=%0d h=%0d got=%h want=%h", f, m_h, bus.o_pixel, want);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_width = 12'd640;
    i_height = 11'd480;
    i_mode = 3'd0;
    i_solid = 24'h0;
    bus.i_rd = 1'b0;
    bus.i_newline = 1'b0;
    bus.i_newframe = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_bars();
    test_checker();
    test_ramp();
    test_back_to_back();
    i_mode = 3'd0;
    test_reset_mid();
    test_box();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
